// File: rtl/dff_bank_arbiter.sv
// -----------------------------------------------------------------------------
// dff_bank_arbiter
//
// Round-robin arbiter and sequencer for one shared WIDTH-bit register. Each of
// NREQ requesters can ask for one command: load its data, preset to all ones,
// clear to zero, or toggle. One requester is granted at a time. Its command is
// committed to the register, and then that requester is acknowledged.
//
// Transaction timeline (req first sampled at edge k):
//   edge k   : IDLE -> GRANT. The winner is chosen, and its op/d are captured.
//   edge k+1 : GRANT -> COMMIT. q is written and the pointer advances.
//              If req[w] has dropped, the transaction aborts: GRANT -> IDLE.
//   edge k+2 : COMMIT -> IDLE
//
// Ports:
//   clk   in   1            rising-edge clock
//   clr   in   1            asynchronous active-high reset
//   req   in   NREQ         request level, bit i = requester i
//   op    in   2*NREQ       op[2i+1:2i]: 00 load, 01 preset, 10 clear, 11 toggle
//   d     in   WIDTH*NREQ   d[WIDTH*i +: WIDTH] = load data of requester i
//   q     out  WIDTH        shared register contents
//   gnt   out  NREQ         one-hot grant, high during GRANT
//   ack   out  NREQ         one-hot completion pulse, high during COMMIT
//   busy  out  1            high whenever not IDLE
// -----------------------------------------------------------------------------
module dff_bank_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       op,
    input  logic [WIDTH*NREQ-1:0]   d,
    output logic [WIDTH-1:0]        q,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic                    busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_PRESET = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_GRANT  = 2'b01,
        S_COMMIT = 2'b10
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;        // first index searched in the next arbitration
    logic [PTR_W-1:0]   win;        // requester owning the current transaction
    logic [1:0]         cmd;        // command captured at grant time
    logic [WIDTH-1:0]   cmd_data;   // load data captured at grant time
    logic [PTR_W-1:0]   pick;       // combinational round-robin winner

    // Returns (i + 1) mod NREQ. This wraps correctly even when NREQ is not a
    // power of two.
    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
        int n;
        n = (int'(i) + 1) % NREQ;
        return PTR_W'(n);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_cmd(input logic [1:0]       c,
                                                   input logic [WIDTH-1:0] data,
                                                   input logic [WIDTH-1:0] cur);
        logic [WIDTH-1:0] r;
        case (c)
            OP_LOAD:   r = data;
            OP_PRESET: r = '1;
            OP_CLEAR:  r = '0;
            OP_TOGGLE: r = ~cur;
            default:   r = cur;
        endcase
        return r;
    endfunction

    // Scan ptr, ptr+1, ... (mod NREQ). The first active request wins.
    // The result is only used when |req is true, so the default value is
    // never used as a winner.
    always_comb begin
        logic found;
        int   idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= S_IDLE;
            q        <= '0;
            gnt      <= '0;
            ack      <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
            win      <= '0;
            cmd      <= '0;
            cmd_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        state    <= S_GRANT;
                        win      <= pick;
                        cmd      <= op[2*int'(pick) +: 2];
                        cmd_data <= d[WIDTH*int'(pick) +: WIDTH];
                        gnt      <= onehot(pick);
                        busy     <= 1'b1;
                    end
                end

                S_GRANT: begin
                    gnt <= '0;
                    if (req[win]) begin
                        q     <= apply_cmd(cmd, cmd_data, q);
                        ptr   <= next_idx(win);
                        ack   <= onehot(win);
                        state <= S_COMMIT;
                    end else begin
                        // The requester withdrew. Leave q and ptr untouched,
                        // so the next search starts from the same index.
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                S_COMMIT: begin
                    ack   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    gnt   <= '0;
                    ack   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dff_bank_arbiter
//
// Self-checking bench for dff_bank_arbiter (WIDTH=4, NREQ=4). A
// transaction-level reference model tracks the register, the rotation
// pointer, and how far the current transaction has progressed. It predicts
// q/gnt/ack/busy after every clock edge. Directed scenarios come first,
// followed by randomized request traffic.
// -----------------------------------------------------------------------------
module tb_dff_bank_arbiter;

    localparam int WIDTH = 4;
    localparam int NREQ  = 4;

    logic                  clk;
    logic                  clr;
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     op;
    logic [WIDTH*NREQ-1:0] d;
    logic [WIDTH-1:0]      q;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  busy;

    dff_bank_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk  (clk),
        .clr  (clr),
        .req  (req),
        .op   (op),
        .d    (d),
        .q    (q),
        .gnt  (gnt),
        .ack  (ack),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model. The age of the transaction is the number of edges
    // since the grant: 0 means no transaction, 1 means granted, and 2 means
    // committed.
    int               m_age;
    int               m_w;
    int               m_ptr;
    logic [1:0]       m_op;
    logic [WIDTH-1:0] m_d;
    logic [WIDTH-1:0] m_q;
    logic [NREQ-1:0]  m_gnt;
    logic [NREQ-1:0]  m_ack;
    logic             m_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_age = 0; m_w = 0; m_ptr = 0; m_op = '0; m_d = '0;
        m_q = '0; m_gnt = '0; m_ack = '0; m_busy = 1'b0;
    endtask

    // Advance the model by one clock edge, using the inputs the DUT saw.
    task automatic model_step();
        m_gnt = '0;
        m_ack = '0;
        if (m_age == 0) begin
            if (req != 0) begin
                for (int k = NREQ - 1; k >= 0; k--)
                    if (req[(m_ptr + k) % NREQ]) m_w = (m_ptr + k) % NREQ;
                m_op  = op[2*m_w +: 2];
                m_d   = d[WIDTH*m_w +: WIDTH];
                m_age = 1;
                m_gnt[m_w] = 1'b1;
            end
        end else if (m_age == 1) begin
            if (req[m_w]) begin
                if (m_op == 2'b00)      m_q = m_d;
                else if (m_op == 2'b01) m_q = {WIDTH{1'b1}};
                else if (m_op == 2'b10) m_q = '0;
                else                    m_q = m_q ^ {WIDTH{1'b1}};
                m_ptr = (m_w + 1) % NREQ;
                m_ack[m_w] = 1'b1;
                m_age = 2;
            end else begin
                m_age = 0;
            end
        end else begin
            m_age = 0;
        end
        m_busy = (m_age != 0);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"},    32'(q),    32'(m_q));
        check({tag, ".gnt"},  32'(gnt),  32'(m_gnt));
        check({tag, ".ack"},  32'(ack),  32'(m_ack));
        check({tag, ".busy"}, 32'(busy), 32'(m_busy));
    endtask

    // Drive the inputs for one cycle, clock once, and compare against the
    // model just after the edge.
    task automatic cycle(input logic [NREQ-1:0] r, input logic [2*NREQ-1:0] o,
                         input logic [WIDTH*NREQ-1:0] dd, input string tag);
        req = r; op = o; d = dd;
        @(posedge clk);
        #1;
        model_step();
        check_all(tag);
    endtask

    // Full three-cycle transaction for one requester that holds req for
    // grant and commit, then drops it during COMMIT.
    task automatic txn(input int idx, input logic [1:0] o, input logic [WIDTH-1:0] data,
                       input string tag);
        logic [NREQ-1:0]       r;
        logic [2*NREQ-1:0]     ov;
        logic [WIDTH*NREQ-1:0] dv;
        r = '0; r[idx] = 1'b1;
        ov = '0; ov[2*idx +: 2] = o;
        dv = '0; dv[WIDTH*idx +: WIDTH] = data;
        cycle(r, ov, dv, tag);
        cycle(r, ov, dv, tag);
        cycle('0, ov, dv, tag);
    endtask

    initial begin
        logic [NREQ-1:0] r;
        model_reset();
        req = '0; op = '0; d = '0;

        // Reset while every requester is asking.
        clr = 1'b1;
        req = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        check("rst.q", 32'(q), 32'h0);
        check("rst.gnt", 32'(gnt), 32'h0);
        check("rst.ack", 32'(ack), 32'h0);
        check("rst.busy", 32'(busy), 32'h0);
        clr = 1'b0;
        cycle(4'b1111, '0, '0, "rst_first");
        check("rst.first_gnt", 32'(gnt), 32'h1);
        cycle(4'b0000, '0, '0, "rst_abort");
        cycle(4'b0000, '0, '0, "rst_idle");

        // Single load by requester 1.
        txn(1, 2'b00, 4'hA, "load1");
        check("load1.q", 32'(q), 32'hA);
        check("load1.busy", 32'(busy), 32'h0);

        // Rotation: all requesters hold, load i+1. The pointer sits at 2 after
        // the load above, so first commit requester 3 to bring it back to 0.
        txn(3, 2'b00, 4'h4, "prep");
        for (int t = 0; t < 5; t++) begin
            cycle(4'b1111, '0, 16'h4321, "rot");
            check("rot.gnt", 32'(gnt), 32'(1 << (t % NREQ)));
            cycle(4'b1111, '0, 16'h4321, "rot");
            check("rot.q", 32'(q), 32'((t % NREQ) + 1));
            cycle(4'b0000, '0, 16'h4321, "rot");
        end

        // Command sequence on requester 2, starting from q=5.
        txn(2, 2'b00, 4'h5, "cmd_load");
        check("cmd.load", 32'(q), 32'h5);
        txn(2, 2'b01, 4'h0, "cmd_preset");
        check("cmd.preset", 32'(q), 32'hF);
        txn(2, 2'b10, 4'h0, "cmd_clear");
        check("cmd.clear", 32'(q), 32'h0);
        txn(2, 2'b11, 4'h0, "cmd_tog1");
        check("cmd.toggle1", 32'(q), 32'hF);
        txn(2, 2'b11, 4'h0, "cmd_tog2");
        check("cmd.toggle2", 32'(q), 32'h0);

        // Abort: put the pointer at 0, then request for one cycle only.
        txn(3, 2'b00, 4'h9, "abort_prep");
        cycle(4'b0001, 8'h00, 16'h0006, "abort");
        check("abort.gnt", 32'(gnt), 32'h1);
        cycle(4'b0000, 8'h00, 16'h0006, "abort");
        check("abort.q", 32'(q), 32'h9);
        check("abort.ack", 32'(ack), 32'h0);
        cycle(4'b1111, '0, 16'h4321, "abort_next");
        check("abort.next_gnt", 32'(gnt), 32'h1);
        cycle(4'b1111, '0, 16'h4321, "abort_next");
        cycle(4'b0000, '0, 16'h4321, "abort_next");

        // Reset during GRANT of a load of 7.
        cycle(4'b0001, 8'h00, 16'h0007, "midrst");
        #2 clr = 1'b1;
        #1;
        check("midrst.q", 32'(q), 32'h0);
        check("midrst.gnt", 32'(gnt), 32'h0);
        check("midrst.ack", 32'(ack), 32'h0);
        check("midrst.busy", 32'(busy), 32'h0);
        #1 clr = 1'b0;
        model_reset();
        cycle(4'b0000, 8'h00, 16'h0007, "midrst_after");
        check("midrst.after_ack", 32'(ack), 32'h0);

        // Randomized traffic. Requests mostly persist, so that many
        // transactions commit, with some aborts and late drops mixed in.
        r = '0;
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 3) == 0) r = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            cycle(r, 8'($urandom), 16'($urandom), "rand");
            if ((gnt & (gnt - 1)) != 0 || (ack & (ack - 1)) != 0 || ((gnt != 0) && (ack != 0)))
                check("rand.onehot", {gnt, ack}, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
Round-robin arbiter and sequencer for a shared WIDTH-bit register built from D flip-flops.
Up to NREQ requesters each issue one command: load data, preset to all ones, clear to zero, or toggle.
The block grants one requester at a time, commits its command to the register, then acknowledges.
It sits between requester logic and the register bank it owns, and replaces direct pr/clr/d wiring when the register is shared.

Parameters:
WIDTH, 4, bit width of the shared register q.
NREQ, 4, number of requesters (2..8); the pointer width is clog2(NREQ).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
clr  input  1  asynchronous, active-high reset.
req  input  NREQ  per-requester request level; bit i belongs to requester i.
op  input  2*NREQ  per-requester command; op[2i+1:2i] belongs to requester i. 00 load, 01 preset, 10 clear, 11 toggle.
d  input  WIDTH*NREQ  per-requester load data; d[WIDTH*i +: WIDTH] belongs to requester i.
q  output  WIDTH  shared register contents (registered).
gnt  output  NREQ  one-hot grant; high during GRANT for the winner only.
ack  output  NREQ  one-hot, one-cycle completion pulse; high during COMMIT.
busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (clr=1, asynchronous): state=IDLE, q=0, gnt=0, ack=0, busy=0, ptr=0, captured op/data=0. Reset has priority over everything.
- Reset mid-transaction aborts it: no write to q, no ack.
- States and transitions:
  - IDLE -> GRANT when any req bit is high at the edge.
  - GRANT -> COMMIT if req[w] is still high; otherwise GRANT -> IDLE (abort).
  - COMMIT -> IDLE unconditionally.
- Winner selection, on the IDLE->GRANT edge:
  - Scan indices ptr, ptr+1, ... NREQ-1, 0, ... ptr-1 (mod NREQ).
  - The first index with req high is the winner w.
  - On the same edge, capture op[w] and d[w] into internal registers. Later changes to op/d are ignored.
- GRANT cycle: gnt[w]=1, all other gnt bits 0, busy=1.
- Abort (req[w] low at the GRANT edge):
  - q unchanged, ptr unchanged, no ack.
  - Return to IDLE; re-arbitration is possible on the next edge.
- Commit (GRANT->COMMIT edge), q is updated from the captured command:
  - load: q = captured data.
  - preset: q = all ones.
  - clear: q = 0.
  - toggle: q = ~q.
  - On the same edge, ptr = (w+1) mod NREQ.
- COMMIT cycle: ack[w]=1 for exactly one cycle, gnt=0, busy=1. q already shows the new value.
- Requesters must drop req during the COMMIT cycle. A req still high at the COMMIT->IDLE edge counts as a new request in IDLE.
- Latency, with req first sampled at edge k:
  - gnt after edge k.
  - q updated at edge k+1.
  - ack during cycle k+1..k+2.
  - IDLE after edge k+2.
  - Minimum transaction time is 3 cycles; back-to-back grants to different requesters occur every 3 cycles.
- Requests arriving while busy wait; they are not queued beyond the req level.
- gnt and ack are never high at the same time. At most one bit of each is high.

Test Plan:
- Reset: clr=1 with req=4'b1111 -> q=0, gnt=0, ack=0, busy=0. After clr falls, the first grant goes to requester 0.
- Single load: req=4'b0010, op1=00, d1=4'hA -> gnt=4'b0010 for 1 cycle; q=4'hA on the next edge; ack=4'b0010 for 1 cycle; busy low after 3 cycles.
- Rotation: req=4'b1111 held, all ops load with d_i=i+1 -> grant order 0,1,2,3,0, one every 3 cycles; q sequence 1,2,3,4,1.
- Commands on one requester from q=4'h5:
  - preset -> q=4'hF.
  - clear -> q=4'h0.
  - toggle -> q=4'hF.
  - toggle -> q=4'h0.
- Abort: req0 high for 1 cycle only -> gnt=4'b0001 for one cycle; q unchanged; ack stays 0; next grant again starts its search at index 0.
- Reset mid-op: assert clr asynchronously during GRANT for a load of 4'h7 -> q=0 immediately, gnt=0, no ack, state IDLE.
